// File: rtl/avmm_run_pkg.sv
// Shared types and constants for the Avalon-MM run sequencer.
// Optional build macro used by the top: RUN_CYCLE_COUNTER_EN.
package avmm_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3
  } run_state_e;

  localparam logic [7:0] OFF_CMD      = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_CFG_BASE = 8'h08;
  localparam logic [7:0] OFF_CNT      = 8'h28;

  localparam int STAT_DONE_BIT = 4;
  localparam int STAT_ERR_BIT  = 5;

  localparam logic [31:0] DEF_START_KEY = 32'hF00B_F00B;
  localparam logic [31:0] DEF_STOP_KEY  = 32'hDEAD_F00B;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/avmm_run_sequencer_if.sv
// Avalon-MM slave bus plus the config-beat stream towards the datapath.
interface avmm_run_sequencer_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_index;
  logic [31:0]       cfg_data;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, cfg_ready,
    input  avs_readdata, avs_readdatavalid, cfg_valid, cfg_index, cfg_data
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, cfg_ready,
    output avs_readdata, avs_readdatavalid, cfg_valid, cfg_index, cfg_data
  );
endinterface

// File: rtl/avmm_csr_decode.sv
// Register address decode, byte-lane merge for CFG writes and the
// one-cycle registered read-data path.
module avmm_csr_decode
  import avmm_run_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int NUM_CFG  = 6,
  parameter int CFG_BASE = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       i_address,
  input  logic                    i_read,
  input  logic                    i_write,
  input  logic [31:0]             i_writedata,
  input  logic [3:0]              i_byteenable,
  input  logic [31:0]             i_status,
  input  logic [31:0]             i_count,
  input  logic [NUM_CFG-1:0][31:0] i_cfg,
  output logic                    o_cmd_wr,
  output logic                    o_status_wr,
  output logic                    o_cfg_wr,
  output logic [2:0]              o_cfg_idx,
  output logic [31:0]             o_cfg_wdata,
  output logic [31:0]             o_readdata,
  output logic                    o_readdatavalid
);

  localparam int WW = ADDR_W - 2;
  localparam logic [WW-1:0] CMD_W     = WW'(OFF_CMD >> 2);
  localparam logic [WW-1:0] STATUS_W  = WW'(OFF_STATUS >> 2);
  localparam logic [WW-1:0] CNT_W     = WW'(OFF_CNT >> 2);
  localparam logic [WW-1:0] CFG_W     = WW'(CFG_BASE >> 2);
  localparam logic [WW-1:0] CFG_END_W = WW'((CFG_BASE >> 2) + NUM_CFG);

  logic [WW-1:0] w_word;
  logic [WW-1:0] w_cfg_off;
  logic          w_cmd_hit;
  logic          w_status_hit;
  logic          w_cfg_hit;
  logic          w_cnt_hit;
  logic [31:0]   w_rdata;
  logic          w_unused_addr;
  logic [31:0]   r_readdata;
  logic          r_readdatavalid;

  assign w_word        = i_address[ADDR_W-1:2];
  assign w_unused_addr = ^i_address[1:0];
  assign w_cfg_off     = w_word - CFG_W;
  assign w_cmd_hit     = (w_word == CMD_W);
  assign w_status_hit  = (w_word == STATUS_W);
  assign w_cnt_hit     = (w_word == CNT_W);
  assign w_cfg_hit     = (w_word >= CFG_W) && (w_word < CFG_END_W);

  assign o_cmd_wr    = i_write && w_cmd_hit;
  assign o_status_wr = i_write && w_status_hit;
  assign o_cfg_wr    = i_write && w_cfg_hit;
  assign o_cfg_idx   = w_cfg_off[2:0];
  assign o_cfg_wdata = be_merge(i_cfg[o_cfg_idx], i_writedata, i_byteenable);

  // Read-data mux; CMD reads mirror STATUS, unmapped addresses return zero.
  always_comb begin
    w_rdata = 32'h0;
    if (w_cmd_hit || w_status_hit) begin
      w_rdata = i_status;
    end else if (w_cfg_hit) begin
      w_rdata = i_cfg[o_cfg_idx];
    end else if (w_cnt_hit) begin
      w_rdata = i_count;
    end else begin
      w_rdata = 32'h0;
    end
  end

  // Read response registered one cycle after the request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_readdata      <= 32'h0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= i_read;
      r_readdata      <= i_read ? w_rdata : 32'h0;
    end
  end

  assign o_readdata      = r_readdata;
  assign o_readdatavalid = r_readdatavalid;

endmodule

// File: rtl/avmm_run_sequencer.sv
// Avalon-MM run sequencer: CFG/CMD/STATUS registers, config streaming FSM.
// Build macro RUN_CYCLE_COUNTER_EN adds a saturating run-cycle counter at 0x28.
module avmm_run_sequencer
  import avmm_run_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          NUM_CFG   = 6,
  parameter int          CFG_BASE  = int'(OFF_CFG_BASE),
  parameter logic [31:0] START_KEY = DEF_START_KEY,
  parameter logic [31:0] STOP_KEY  = DEF_STOP_KEY
) (
  input  logic                 clock,
  input  logic                 reset,
  avmm_run_sequencer_if.slave  bus,
  output logic                 run_en,
  input  logic                 dp_done,
  output logic                 irq
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_CFG - 1);

  run_state_e               r_state;
  logic [2:0]               r_idx;
  logic                     r_abort;
  logic                     r_cfg_valid;
  logic [31:0]              r_cfg_data;
  logic                     r_run_en;
  logic                     r_done;
  logic                     r_err;
  logic                     r_irq;
  logic [NUM_CFG-1:0][31:0] r_cfg;

  logic        w_cmd_wr, w_status_wr, w_cfg_wr;
  logic [2:0]  w_cfg_idx;
  logic [31:0] w_cfg_wdata;
  logic [31:0] w_status;
  logic [31:0] w_count;
  logic [2:0]  w_idx_inc;
  logic        w_cmd_full, w_start, w_stop, w_hs, w_idle;
  logic        w_err_set, w_done_set, w_err_nxt, w_done_nxt;

  assign w_status  = {26'h0, r_err, r_done, 1'b0, r_state};
  assign w_idle    = (r_state == ST_IDLE);
  assign w_idx_inc = r_idx + 3'd1;

  avmm_csr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_CFG  (NUM_CFG),
    .CFG_BASE (CFG_BASE)
  ) u_decode (
    .clock           (clock),
    .reset           (reset),
    .i_address       (bus.avs_address),
    .i_read          (bus.avs_read),
    .i_write         (bus.avs_write),
    .i_writedata     (bus.avs_writedata),
    .i_byteenable    (bus.avs_byteenable),
    .i_status        (w_status),
    .i_count         (w_count),
    .i_cfg           (r_cfg),
    .o_cmd_wr        (w_cmd_wr),
    .o_status_wr     (w_status_wr),
    .o_cfg_wr        (w_cfg_wr),
    .o_cfg_idx       (w_cfg_idx),
    .o_cfg_wdata     (w_cfg_wdata),
    .o_readdata      (bus.avs_readdata),
    .o_readdatavalid (bus.avs_readdatavalid)
  );

  // Command qualification and sticky-bit next values (set beats W1C clear).
  always_comb begin
    w_cmd_full = w_cmd_wr && (bus.avs_byteenable == 4'hF);
    w_start    = w_cmd_full && (bus.avs_writedata == START_KEY);
    w_stop     = w_cmd_full && (bus.avs_writedata == STOP_KEY);
    w_hs       = r_cfg_valid && bus.cfg_ready;
    w_err_set  = (w_cmd_wr && !(w_start || w_stop)) ||
                 (w_start && !w_idle) ||
                 (w_cfg_wr && !w_idle);
    w_done_set = (r_state == ST_DONE);
    w_done_nxt = w_done_set ||
                 (r_done && !(w_status_wr && bus.avs_writedata[STAT_DONE_BIT]));
    w_err_nxt  = w_err_set ||
                 (r_err && !(w_status_wr && bus.avs_writedata[STAT_ERR_BIT]));
  end

  // Sticky status bits and the level interrupt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      r_irq  <= w_done_nxt || w_err_nxt;
    end
  end

  // CFG storage; frozen outside IDLE so beats stay stable during a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cfg <= '0;
    end else if (w_cfg_wr && w_idle) begin
      r_cfg[w_cfg_idx] <= w_cfg_wdata;
    end else begin
      r_cfg <= r_cfg;
    end
  end

  // Sequencer FSM with registered stream and run outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_abort     <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_cfg_data  <= 32'h0;
      r_run_en    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_LOAD;
            r_idx       <= 3'd0;
            r_abort     <= 1'b0;
            r_cfg_valid <= 1'b1;
            r_cfg_data  <= r_cfg[3'd0];
          end
        end
        ST_LOAD: begin
          if (w_hs) begin
            if (r_abort || w_stop) begin
              r_state     <= ST_IDLE;
              r_cfg_valid <= 1'b0;
              r_abort     <= 1'b0;
            end else if (r_idx == LAST_IDX) begin
              r_state     <= ST_RUN;
              r_cfg_valid <= 1'b0;
              r_run_en    <= 1'b1;
            end else begin
              r_idx      <= w_idx_inc;
              r_cfg_data <= r_cfg[w_idx_inc];
            end
          end else if (w_stop) begin
            r_abort <= 1'b1;
          end
        end
        ST_RUN: begin
          if (dp_done) begin
            r_state  <= ST_DONE;
            r_run_en <= 1'b0;
          end else if (w_stop) begin
            r_state  <= ST_IDLE;
            r_run_en <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cfg_valid <= 1'b0;
          r_run_en    <= 1'b0;
          r_abort     <= 1'b0;
        end
      endcase
    end
  end

`ifdef RUN_CYCLE_COUNTER_EN
  logic [31:0] r_run_cnt;

  // Run-cycle counter: cleared when a load starts, saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run_cnt <= 32'h0;
    end else if (w_idle && w_start) begin
      r_run_cnt <= 32'h0;
    end else if (r_run_en && (r_run_cnt != 32'hFFFF_FFFF)) begin
      r_run_cnt <= r_run_cnt + 32'd1;
    end else begin
      r_run_cnt <= r_run_cnt;
    end
  end

  assign w_count = r_run_cnt;
`else
  assign w_count = 32'h0;
`endif

  assign bus.cfg_valid = r_cfg_valid;
  assign bus.cfg_index = r_idx;
  assign bus.cfg_data  = r_cfg_data;
  assign run_en        = r_run_en;
  assign irq           = r_irq;

endmodule

// File: tb/tb_avmm_run_sequencer.sv
// Randomized self-checking bench for avmm_run_sequencer with a register-level model.
module tb_avmm_run_sequencer;
  import avmm_run_pkg::*;

  localparam logic [31:0] START = 32'hF00B_F00B;
  localparam logic [31:0] STOP  = 32'hDEAD_F00B;

  logic clock = 1'b0;
  logic reset;
  logic run_en, dp_done, irq;

  avmm_run_sequencer_if #(.ADDR_W(32)) bus ();

  avmm_run_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .run_en  (run_en),
    .dp_done (dp_done),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents and sticky bits from the register rules.
  logic [31:0] m_cfg [8];
  logic        m_done, m_err;
  int          m_state;
  int          beat_idx_q[$];
  logic [31:0] beat_data_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {26'h0, m_err, m_done, 1'b0, 3'(m_state)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cfg[i] = 32'h0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_state = 0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    if (addr == 32'h0) begin
      if (be != 4'hF) m_err = 1'b1;
      else if (data == START) begin
        if (m_state == 0) m_state = 1;
        else m_err = 1'b1;
      end else if (data == STOP) begin
        if (m_state == 2) m_state = 0;
      end else m_err = 1'b1;
    end else if (addr == 32'h4) begin
      if (data[4]) m_done = 1'b0;
      if (data[5]) m_err = 1'b0;
    end else if (addr >= 32'h8 && addr < 32'h20) begin
      if (m_state == 0) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_cfg[(addr - 32'h8) / 4][8*b +: 8] = data[8*b +: 8];
      end else m_err = 1'b1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    model_write(addr, data, be);
    bus.avs_address    = addr;
    bus.avs_writedata  = data;
    bus.avs_byteenable = be;
    bus.avs_write      = 1'b1;
    @(posedge clock); #1;
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    @(posedge clock); #1;
    bus.avs_read = 1'b0;
    chk("readdatavalid", bus.avs_readdatavalid, 1'b1);
    data = bus.avs_readdata;
  endtask

  task automatic wait_run();
    int g = 0;
    while (!run_en && g < 100) begin
      @(posedge clock); #1;
      g++;
    end
    chk("run_wait", run_en, 1'b1);
    m_state = 2;
  endtask

  // Beat monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clock) begin
    if (!reset && bus.cfg_valid && bus.cfg_ready) begin
      beat_idx_q.push_back(int'(bus.cfg_index));
      beat_data_q.push_back(bus.cfg_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] val;
    int          g;
    int          idx;
    logic [3:0]  be;

    bus.avs_address    = 32'h0;
    bus.avs_read       = 1'b0;
    bus.avs_write      = 1'b0;
    bus.avs_writedata  = 32'h0;
    bus.avs_byteenable = 4'h0;
    bus.cfg_ready      = 1'b0;
    dp_done            = 1'b0;
    reset              = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_cfg_valid", bus.cfg_valid, 1'b0);
    chk("rst_run_en", run_en, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_rdv", bus.avs_readdatavalid, 1'b0);
    bus_read(32'h4, rd);
    chk("rst_status", rd, exp_status());

    // CFG write / readback, read strobe lasts exactly one cycle
    for (int i = 0; i < 6; i++) begin
      val = 32'(i + 1) * 32'h1111_0000 + 32'h0000_F000;
      bus_write(32'h8 + 32'(4 * i), val, 4'hF);
    end
    for (int i = 0; i < 6; i++) begin
      bus_read(32'h8 + 32'(4 * i), rd);
      chk("cfg_readback", rd, m_cfg[i]);
      @(posedge clock); #1;
      chk("rdv_one_cycle", bus.avs_readdatavalid, 1'b0);
    end
    repeat (8) begin
      idx = $urandom_range(0, 5);
      be  = 4'($urandom_range(1, 14));
      bus_write(32'h8 + 32'(4 * idx), $urandom, be);
      bus_read(32'h8 + 32'(4 * idx), rd);
      chk("cfg_byteenable", rd, m_cfg[idx]);
    end
    bus_read(32'h20, rd);
    chk("unmapped_20", rd, 32'h0);
    bus_read(32'h40, rd);
    chk("unmapped_40", rd, 32'h0);
    bus_read(32'h28, rd);
    chk("cnt_before_run", rd, 32'h0);
    for (int i = 0; i < 6; i++) begin
      val = 32'(i + 1) * 32'h1111_0000 + 32'h0000_F000;
      bus_write(32'h8 + 32'(4 * i), val, 4'hF);
    end

    // Full load with cfg_ready held high
    bus.cfg_ready = 1'b1;
    beat_idx_q.delete();
    beat_data_q.delete();
    bus_write(32'h0, START, 4'hF);
    for (int i = 0; i < 6; i++) begin
      chk("load_valid", bus.cfg_valid, 1'b1);
      chk("load_index", 32'(bus.cfg_index), 32'(i));
      chk("load_data", bus.cfg_data, m_cfg[i]);
      @(posedge clock); #1;
    end
    chk("run_after_load", run_en, 1'b1);
    chk("valid_after_load", bus.cfg_valid, 1'b0);
    m_state = 2;
    chk("beats_full", 32'(beat_idx_q.size()), 32'd6);
    bus_read(32'h4, rd);
    chk("status_run", rd, exp_status());

    // Stop from RUN
    repeat (40) @(posedge clock);
    #1;
    chk("run_held", run_en, 1'b1);
    bus_write(32'h0, STOP, 4'hF);
    chk("stop_run_en", run_en, 1'b0);
    bus_read(32'h4, rd);
    chk("status_stopped", rd, exp_status());
    chk("irq_stopped", irq, 1'b0);
`ifdef RUN_CYCLE_COUNTER_EN
    bus_read(32'h28, rd);
    chk("run_cnt_range", 32'((rd >= 32'd39) && (rd <= 32'd42)), 32'd1);
`else
    bus_read(32'h28, rd);
    chk("cnt_absent", rd, 32'h0);
`endif

    // Random backpressure, then STOP while stalled on index 2
    bus.cfg_ready = 1'b0;
    beat_idx_q.delete();
    beat_data_q.delete();
    bus_write(32'h0, START, 4'hF);
    g = 0;
    while (beat_idx_q.size() < 2 && g < 60) begin
      bus.cfg_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      g++;
    end
    bus.cfg_ready = 1'b0;
    chk("bp_two_beats", 32'(beat_idx_q.size()), 32'd2);
    chk("bp_index", 32'(bus.cfg_index), 32'd2);
    chk("bp_data", bus.cfg_data, 32'h3333_F000);
    @(posedge clock); #1;
    chk("bp_hold1", bus.cfg_data, m_cfg[2]);
    bus_write(32'h0, STOP, 4'hF);
    chk("bp_hold2", bus.cfg_data, m_cfg[2]);
    chk("bp_valid_held", bus.cfg_valid, 1'b1);
    @(posedge clock); #1;
    chk("bp_hold3", bus.cfg_data, m_cfg[2]);
    bus.cfg_ready = 1'b1;
    @(posedge clock); #1;
    bus.cfg_ready = 1'b0;
    m_state = 0;
    chk("abort_valid", bus.cfg_valid, 1'b0);
    chk("abort_run_en", run_en, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("abort_beats", 32'(beat_idx_q.size()), 32'd3);
    for (int i = 0; i < beat_idx_q.size(); i++) begin
      chk("abort_beat_idx", 32'(beat_idx_q[i]), 32'(i));
      chk("abort_beat_data", beat_data_q[i], m_cfg[i]);
    end
    bus_read(32'h4, rd);
    chk("abort_status", rd, exp_status());

    // Error cases while running
    bus.cfg_ready = 1'b1;
    bus_write(32'h0, START, 4'hF);
    wait_run();
    bus_write(32'h0, START, 4'hF);
    chk("irq_err", irq, 1'b1);
    bus_write(32'hC, 32'hCAFE_0001, 4'hF);
    bus_write(32'h0, 32'h1234_5678, 4'hF);
    bus_write(32'h0, STOP, 4'h3);
    chk("partial_stop_run", run_en, 1'b1);
    bus_read(32'h4, rd);
    chk("status_err", rd, exp_status());
    bus_read(32'hC, rd);
    chk("cfg_unchanged", rd, m_cfg[1]);
    bus_write(32'h4, 32'h20, 4'hF);
    chk("irq_err_clr", irq, 1'b0);
    bus_read(32'h0, rd);
    chk("cmd_mirror", rd, exp_status());

    // dp_done and STOP in the same cycle: completion wins
    dp_done = 1'b1;
    bus_write(32'h0, STOP, 4'hF);
    dp_done = 1'b0;
    m_state = 3;
    chk("done_run_en", run_en, 1'b0);
    bus_read(32'h4, rd);
    chk("status_done_state", rd & 32'h7, 32'd3);
    m_state = 0;
    m_done  = 1'b1;
    chk("irq_done", irq, 1'b1);
    bus_read(32'h4, rd);
    chk("status_done", rd, exp_status());
    bus_write(32'h4, 32'h10, 4'hF);
    chk("irq_done_clr", irq, 1'b0);

    // dp_done outside RUN is ignored
    dp_done = 1'b1;
    @(posedge clock); #1;
    dp_done = 1'b0;
    bus_read(32'h4, rd);
    chk("done_idle_ignored", rd, exp_status());

    // W1C clear in the same cycle as the DONE set: set wins
    bus_write(32'h0, START, 4'hF);
    wait_run();
    dp_done = 1'b1;
    @(posedge clock); #1;
    dp_done = 1'b0;
    bus_write(32'h4, 32'h10, 4'hF);
    m_done  = 1'b1;
    m_state = 0;
    bus_read(32'h4, rd);
    chk("set_beats_clear", rd, exp_status());
    bus_write(32'h4, 32'h30, 4'hF);
    chk("irq_all_clr", irq, 1'b0);

    // Asynchronous reset in the middle of a load
    bus.cfg_ready = 1'b0;
    bus_write(32'h0, START, 4'hF);
    chk("pre_reset_valid", bus.cfg_valid, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_valid", bus.cfg_valid, 1'b0);
    chk("async_reset_run", run_en, 1'b0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    bus_read(32'h4, rd);
    chk("post_reset_status", rd, exp_status());
    bus_read(32'h8, rd);
    chk("post_reset_cfg0", rd, m_cfg[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avmm_run_sequencer.md
Name: avmm_run_sequencer

Overview:
Avalon-MM slave control block fronting one compute datapath. It holds six configuration words and a command/status register. On the START key it streams the config words into the datapath over a valid/ready port, then asserts run. It halts on the STOP key or on datapath completion. The host Avalon-MM master drives it through the system interconnect.

Parameters:
ADDR_W, 32, avs_address width (byte address)
NUM_CFG, 6, number of config words (max 8)
CFG_BASE, 8, byte address of CFG0; CFGn at CFG_BASE+4n
START_KEY, 32'hF00BF00B, CMD write value that starts a run
STOP_KEY, 32'hDEADF00B, CMD write value that stops a run

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
avs_address  in  ADDR_W  byte address; bits [1:0] ignored
avs_read  in  1  read request
avs_write  in  1  write request
avs_writedata  in  32  write data
avs_byteenable  in  4  byte lanes
avs_readdata  out  32  read data
avs_readdatavalid  out  1  read data strobe
cfg_valid  out  1  config beat valid
cfg_ready  in  1  datapath accepts beat
cfg_index  out  3  config word index
cfg_data  out  32  config word
run_en  out  1  datapath run enable
dp_done  in  1  single-cycle completion pulse
irq  out  1  level interrupt = done_sticky | err_sticky

Behaviour:
- Reset values: all outputs 0; CFG regs 0; state IDLE; sticky bits 0.
- Register map: 0x00 CMD (write: key; read: STATUS mirror); 0x04 STATUS (RO; [2:0] state, [4] done_sticky, [5] err_sticky); CFG_BASE.. CFG regs RW, byte-lane masked.
- Writes to STATUS clear sticky bits where writedata bit = 1 (W1C). Writes to any other address are dropped.
- No waitrequest; every access is accepted in the cycle presented.
- Read: avs_readdatavalid = 1 exactly one cycle after avs_read, with data sampled at the request cycle. Unmapped reads return 0.
- CMD key valid only with byteenable = 4'hF. Any other value or partial enable sets err_sticky.
- FSM (encoding 0 IDLE, 1 LOAD, 2 RUN, 3 DONE):
  - IDLE→LOAD on START_KEY write; index = 0.
  - LOAD: cfg_valid = 1, cfg_index = idx, cfg_data = CFG[idx]. Data holds stable until cfg_ready. On handshake idx++. The handshake at idx = NUM_CFG-1 goes to RUN next cycle.
  - RUN: run_en = 1. On dp_done go to DONE; on STOP_KEY go to IDLE. run_en is 0 in the cycle after the transition.
  - DONE: set done_sticky, go to IDLE next cycle.
- STOP_KEY in LOAD: set abort flag. Finish the current beat's handshake, then IDLE with cfg_valid = 0; no err.
- STOP_KEY in IDLE: no-op.
- START_KEY outside IDLE: ignored, sets err_sticky.
- CFG write outside IDLE: dropped, sets err_sticky.
- dp_done and STOP_KEY in the same RUN cycle: dp_done wins (DONE, done_sticky set).
- dp_done outside RUN: ignored.
- W1C clear and a set event in the same cycle: set wins.
- Asynchronous reset mid-LOAD/RUN: cfg_valid and run_en drop immediately; all state returns to reset values.

Optional Feature:
RUN_CYCLE_COUNTER_EN
- Defined: 32-bit counter at byte address 0x28 (RO).
  - Cleared on IDLE→LOAD.
  - Increments each cycle run_en = 1.
  - Saturates at 32'hFFFFFFFF.
- Undefined: address 0x28 reads 0, and no counter flops exist.

Decomposition:
- Package avmm_run_pkg: state enum (IDLE/LOAD/RUN/DONE), register offset constants (CMD, STATUS, CFG_BASE, CNT), STATUS bit positions, default keys.
- One sub-module, avmm_csr_decode: address decode, byteenable merge and the registered read-data path. The FSM stays in the top module.

Test Plan:
- CFG write/readback: write 0x1111F000..0x6666F000 to 8..28 → read back each with readdatavalid exactly 1 cycle after the read.
- Full load: START 0xF00BF00B with cfg_ready tied 1 → six beats idx 0..5 on consecutive cycles, then run_en = 1. STATUS reads 2.
- Stop from RUN: after 40 cycles write 0xDEADF00B → run_en = 0 the next cycle, STATUS = 0, irq = 0. With the feature defined, count reads 40 ±1 per documented edge.
- Backpressure: cfg_ready low 3 cycles on idx 2, with STOP issued during the stall → cfg_data holds 0x3333F000, then IDLE after the idx-2 handshake; no idx 3 beat.
- Errors: START in RUN, CFG write in RUN, key 0x12345678 → err_sticky = 1, irq = 1, CFG unchanged. Write 0x20 to STATUS → err cleared, irq = 0.
- Completion: dp_done pulse in RUN, same cycle as STOP → DONE then IDLE, done_sticky = 1. Asserting reset mid-LOAD → cfg_valid = 0 asynchronously.
